axil_cmd_sequencer: RTL and testbench

Upstream command stage for axi4_lite_top. Accepts read/write commands from a client over a valid/ready interface and buffers them in a small FIFO. Issues each command to axi4_lite_top as a one-cycle read_s/write_s pulse, holding address/W_data stable, and waits for completion before issuing the next. Read results, or timeouts, are returned to the client over a valid/ready response port.

---
 rtl/axil_seq_pkg.sv | 23 ++
 rtl/axil_cmd_fifo.sv | 58 +++++
 rtl/axil_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_axil_cmd_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_seq_pkg.sv
// Shared types and widths for the AXI4-Lite command sequencer.
package axil_seq_pkg;

  localparam int AXIL_DW = 32;
  localparam int AXIL_AW = 32;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WR_WAIT = 3'd2,
    RD_WAIT = 3'd3,
    RSP     = 3'd4
  } seq_state_t;

  // One queued client command
  typedef struct packed {
    logic               write;
    logic [AXIL_AW-1:0] addr;
    logic [AXIL_DW-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous command FIFO. The head entry is visible combinationally so the
// sequencer can latch it in the same cycle it pops.
module axil_cmd_fifo
  import axil_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; the count carries the extra bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axil_cmd_sequencer.sv
// Buffers client read/write commands and issues them one at a time to
// axi4_lite_top as single-cycle start pulses, returning read results or
// timeouts over a valid/ready response port.
module axil_cmd_sequencer
  import axil_seq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int WR_SETTLE  = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [AXIL_AW-1:0]       cmd_addr,
  input  logic [AXIL_DW-1:0]       cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [AXIL_DW-1:0]       rsp_rdata,
  output logic                     rsp_err,
  output logic                     read_s,
  output logic                     write_s,
  output logic [AXIL_AW-1:0]       address,
  output logic [AXIL_DW-1:0]       W_data,
  input  logic [AXIL_DW-1:0]       read_data_out,
  input  logic                     read_valid_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam logic [7:0] WR_LOAD = 8'(WR_SETTLE - 1);
  localparam logic [7:0] RD_LOAD = 8'(RD_TIMEOUT - 1);

  seq_state_t state;
  seq_state_t state_next;
  logic [7:0] cnt;
  cmd_t       push_data;
  cmd_t       head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       issue_load;
  logic       cnt_zero;
  logic       rsp_capture;
  logic       rsp_release;

  assign push_data = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign cnt_zero  = (cnt == 8'd0);

  axil_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (cmd_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (cmd_count)
  );

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; data beats a same-cycle timeout in RD_WAIT
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = head.write ? WR_WAIT : RD_WAIT;
      WR_WAIT: if (cnt_zero) state_next = IDLE;
      RD_WAIT: if (read_valid_out || cnt_zero) state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode for the datapath registers
  always_comb begin
    issue_load  = (state == IDLE) && !fifo_empty;
    pop         = (state == ISSUE);
    rsp_capture = (state == RD_WAIT) && (read_valid_out || cnt_zero);
    rsp_release = (state == RSP) && rsp_ready;
  end

  // Latch the head command and raise the start pulse for the ISSUE cycle
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      read_s  <= 1'b0;
      write_s <= 1'b0;
      address <= '0;
      W_data  <= '0;
    end else begin
      read_s  <= issue_load && !head.write;
      write_s <= issue_load && head.write;
      if (issue_load) begin
        address <= head.addr;
        W_data  <= head.write ? head.wdata : '0;
      end
    end
  end

  // Settle/timeout counter, loaded while issuing and counted down while waiting
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt <= 8'd0;
    end else if (state == ISSUE) begin
      cnt <= head.write ? WR_LOAD : RD_LOAD;
    end else if (((state == WR_WAIT) || (state == RD_WAIT)) && !cnt_zero) begin
      cnt <= cnt - 8'd1;
    end
  end

  // Response register, held stable until the client accepts it
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (rsp_capture) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= read_valid_out ? read_data_out : '0;
      rsp_err   <= !read_valid_out;
    end else if (rsp_release) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_cmd_sequencer.sv
// Directed bench for axil_cmd_sequencer with a small memory-backed stub
// standing in for axi4_lite_top.
module tb_axil_cmd_sequencer;

  localparam int DEPTH      = 4;
  localparam int WR_SETTLE  = 4;
  localparam int RD_TIMEOUT = 16;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        read_s;
  logic        write_s;
  logic [31:0] address;
  logic [31:0] W_data;
  logic [31:0] read_data_out;
  logic        read_valid_out;
  logic        busy;
  logic [2:0]  cmd_count;

  always #5 ACLK = ~ACLK;

  axil_cmd_sequencer #(
    .DEPTH(DEPTH), .WR_SETTLE(WR_SETTLE), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .read_s(read_s), .write_s(write_s),
    .address(address), .W_data(W_data),
    .read_data_out(read_data_out), .read_valid_out(read_valid_out),
    .busy(busy), .cmd_count(cmd_count)
  );

  // Downstream stub: stores writes, answers reads two cycles after read_s
  logic [31:0] smem [16];
  logic        rv_d1;
  logic [31:0] rd_d1;
  logic        stub_dead = 1'b0;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rv_d1          <= 1'b0;
      rd_d1          <= '0;
      read_valid_out <= 1'b0;
      read_data_out  <= '0;
    end else begin
      if (write_s) smem[address[3:0]] <= W_data;
      rv_d1          <= read_s && !stub_dead;
      rd_d1          <= smem[address[3:0]];
      read_valid_out <= rv_d1;
      read_data_out  <= rv_d1 ? rd_d1 : 32'h0;
    end
  end

  // Transaction monitor
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    int          cyc;
  } iss_t;
  typedef struct packed {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   cyc = 0;
  int   viol = 0;
  logic prev_pulse = 1'b0;

  always @(posedge ACLK) begin
    cyc++;
    if (!ARESETN) begin
      prev_pulse = 1'b0;
    end else begin
      if (read_s && write_s) viol++;
      if ((read_s || write_s) && prev_pulse) viol++;
      prev_pulse = read_s || write_s;
      if (read_s || write_s) begin
        iss_q.push_back('{w: write_s, a: address, d: W_data, cyc: cyc});
        $display("issue  %s addr=%h data=%h cyc=%0d", write_s ? "WR" : "RD", address, W_data, cyc);
      end
      if (rsp_valid && rsp_ready) begin
        rsp_q.push_back('{d: rsp_rdata, e: rsp_err, cyc: cyc});
        $display("resp   rdata=%h err=%0b cyc=%0d", rsp_rdata, rsp_err, cyc);
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a command and hold it until accepted (called at a negedge)
  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int n = 0; n < 300 && !done; n++) begin
      if (cmd_ready) done = 1;
      @(negedge ACLK);
    end
    cmd_valid = 1'b0;
    check("push_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      if (!busy && !rsp_valid) break;
      @(negedge ACLK);
    end
    repeat (3) @(negedge ACLK);
    check("idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic exp_issue(input int idx, input logic w, input logic [31:0] a, input logic [31:0] d);
    check("issue_present", {31'b0, idx < iss_q.size()}, 32'd1);
    if (idx < iss_q.size()) begin
      check("issue_kind", {31'b0, iss_q[idx].w}, {31'b0, w});
      check("issue_addr", iss_q[idx].a, a);
      check("issue_data", iss_q[idx].d, d);
    end
  endtask

  task automatic exp_rsp(input int idx, input logic [31:0] d, input logic e);
    check("rsp_present", {31'b0, idx < rsp_q.size()}, 32'd1);
    if (idx < rsp_q.size()) begin
      check("rsp_rdata", rsp_q[idx].d, d);
      check("rsp_err", {31'b0, rsp_q[idx].e}, {31'b0, e});
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge ACLK);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_pulses", {30'b0, read_s, write_s}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_wdata", W_data, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_count", {29'b0, cmd_count}, 32'd0);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // Write then read
    iss_q.delete(); rsp_q.delete();
    push_cmd(1'b1, 32'd7, 32'h0DEADBEE);
    push_cmd(1'b0, 32'd7, 32'h0);
    wait_idle();
    check("t1_nissue", 32'(iss_q.size()), 32'd2);
    exp_issue(0, 1'b1, 32'd7, 32'h0DEADBEE);
    exp_issue(1, 1'b0, 32'd7, 32'h0);
    if (iss_q.size() == 2)
      check("t1_wr_spacing", 32'(iss_q[1].cyc - iss_q[0].cyc), 32'(WR_SETTLE + 2));
    check("t1_nrsp", 32'(rsp_q.size()), 32'd1);
    exp_rsp(0, 32'h0DEADBEE, 1'b0);
    check("t1_addr_hold", address, 32'd7);
    check("t1_wdata_hold", W_data, 32'd0);

    // Overwrite
    iss_q.delete(); rsp_q.delete();
    push_cmd(1'b1, 32'd7, 32'h0DEADBE0);
    push_cmd(1'b0, 32'd7, 32'h0);
    wait_idle();
    check("t2_nrsp", 32'(rsp_q.size()), 32'd1);
    exp_rsp(0, 32'h0DEADBE0, 1'b0);

    // Full FIFO with a pending response
    iss_q.delete(); rsp_q.delete();
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'd7, 32'h0);
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'(i), 32'h100 + 32'(i));
    check("t3_count_full", {29'b0, cmd_count}, 32'd4);
    check("t3_ready_low", {31'b0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'd4; cmd_wdata = 32'h104;
    repeat (5) @(negedge ACLK);
    check("t3_stall_count", {29'b0, cmd_count}, 32'd4);
    check("t3_stall_ready", {31'b0, cmd_ready}, 32'd0);
    check("t3_stall_issues", 32'(iss_q.size()), 32'd1);
    check("t3_rsp_pending", {31'b0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    push_cmd(1'b1, 32'd4, 32'h104);
    wait_idle();
    check("t3_nissue", 32'(iss_q.size()), 32'd6);
    exp_issue(0, 1'b0, 32'd7, 32'h0);
    for (int i = 0; i < 5; i++) exp_issue(i + 1, 1'b1, 32'(i), 32'h100 + 32'(i));
    check("t3_nrsp", 32'(rsp_q.size()), 32'd1);
    exp_rsp(0, 32'h0DEADBE0, 1'b0);

    // Backpressure on the response port
    iss_q.delete(); rsp_q.delete();
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'd3, 32'h0);
    for (int n = 0; n < 50; n++) begin
      if (rsp_valid) break;
      @(negedge ACLK);
    end
    check("t4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    push_cmd(1'b1, 32'd5, 32'h55);
    for (int n = 0; n < 10; n++) begin
      check("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("t4_hold_rdata", rsp_rdata, 32'h103);
      @(negedge ACLK);
    end
    check("t4_no_issue", 32'(iss_q.size()), 32'd1);
    check("t4_queued", {29'b0, cmd_count}, 32'd1);
    rsp_ready = 1'b1;
    wait_idle();
    check("t4_nissue", 32'(iss_q.size()), 32'd2);
    exp_issue(1, 1'b1, 32'd5, 32'h55);
    check("t4_nrsp", 32'(rsp_q.size()), 32'd1);
    exp_rsp(0, 32'h103, 1'b0);

    // Read timeout: RD_TIMEOUT wait cycles follow the read_s cycle
    iss_q.delete(); rsp_q.delete();
    stub_dead = 1'b1;
    push_cmd(1'b0, 32'd7, 32'h0);
    wait_idle();
    check("t5_nrsp", 32'(rsp_q.size()), 32'd1);
    exp_rsp(0, 32'h0, 1'b1);
    if (rsp_q.size() == 1 && iss_q.size() == 1)
      check("t5_latency", 32'(rsp_q[0].cyc - iss_q[0].cyc), 32'(RD_TIMEOUT + 1));

    // Reset during RD_WAIT with two commands queued
    iss_q.delete(); rsp_q.delete();
    push_cmd(1'b0, 32'd7, 32'h0);
    push_cmd(1'b1, 32'd1, 32'h11);
    push_cmd(1'b1, 32'd2, 32'h22);
    repeat (2) @(negedge ACLK);
    check("t6_queued", {29'b0, cmd_count}, 32'd2);
    ARESETN = 1'b0;
    #1;
    check("t6_count", {29'b0, cmd_count}, 32'd0);
    check("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_read_s", {31'b0, read_s}, 32'd0);
    check("t6_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("t6_address", address, 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    stub_dead = 1'b0;
    repeat (30) @(negedge ACLK);
    check("t6_no_issue", 32'(iss_q.size()), 32'd1);
    check("t6_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("t6_busy", {31'b0, busy}, 32'd0);

    check("pulse_rules", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
